// File: rtl/sim_mem_wait.sv
// Simulation word memory for the rv32im_SoC memory port with configurable read/write
// wait states, a tohost end-of-simulation register and sticky error flags.
module sim_mem_wait #(
    parameter string       INIT_FILE   = "",
    parameter int          DEPTH_WORDS = 16384,
    parameter int          READ_LAT    = 1,
    parameter int          WRITE_LAT   = 1,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_FFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        mem_wbusy,
    output logic        sim_done,
    output logic [31:0] sim_code,
    output logic        oob_err,
    output logic        proto_err
);
    localparam int AW      = $clog2(DEPTH_WORDS);
    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CW      = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] RD_LOAD  = CW'(READ_LAT - 1);
    localparam logic [CW-1:0] WR_LOAD  = CW'(WRITE_LAT - 1);

    logic [31:0]   mem_r [DEPTH_WORDS];
    logic [CW-1:0] rd_cnt_r, wr_cnt_r, rd_cnt_s, wr_cnt_s;
    logic [31:0]   rd_pend_r, rdata_r, sim_code_r;
    logic          rbusy_r, wbusy_r, sim_done_r, oob_err_r, proto_err_r;
    logic [AW-1:0] idx_s;
    logic          busy_s, wr_req_s, is_tohost_s, is_oob_s;
    logic          rd_fire_s, wr_fire_s, proto_s;
    logic [31:0]   rd_val_s, code_merged_s;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = lanes[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

    // Address decode, request qualification and counter next-state
    always_comb begin
        idx_s         = mem_addr[AW+1:2];
        busy_s        = (rd_cnt_r != CNT_ZERO) || (wr_cnt_r != CNT_ZERO);
        is_tohost_s   = ({mem_addr[31:2], 2'b00} == TOHOST_ADDR);
        is_oob_s      = !is_tohost_s && ((mem_addr >> (AW + 2)) != 32'h0);
        wr_req_s      = (mem_wmask != 4'h0);
        wr_fire_s     = wr_req_s && !busy_s;
        // a simultaneous read+write performs only the write
        rd_fire_s     = mem_rstrb && !wr_req_s && !busy_s;
        proto_s       = ((mem_rstrb || wr_req_s) && busy_s) || (mem_rstrb && wr_req_s);
        code_merged_s = merge_lanes(sim_code_r, mem_wdata, mem_wmask);
        rd_val_s      = 32'h0;
        if (is_tohost_s) begin
            rd_val_s = sim_code_r;
        end else if (is_oob_s) begin
            rd_val_s = 32'h0;
        end else begin
            rd_val_s = mem_r[idx_s];
        end
        rd_cnt_s = rd_cnt_r;
        if (rd_fire_s) begin
            rd_cnt_s = RD_LOAD;
        end else if (rd_cnt_r != CNT_ZERO) begin
            rd_cnt_s = rd_cnt_r - CNT_ONE;
        end else begin
            rd_cnt_s = rd_cnt_r;
        end
        wr_cnt_s = wr_cnt_r;
        if (wr_fire_s) begin
            wr_cnt_s = WR_LOAD;
        end else if (wr_cnt_r != CNT_ZERO) begin
            wr_cnt_s = wr_cnt_r - CNT_ONE;
        end else begin
            wr_cnt_s = wr_cnt_r;
        end
    end

    // Array storage starts at zero
    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem_r[i] = 32'h0;
        end
    end

    // Array storage: lane-masked writes (untouched by reset)
    always @(posedge clk) begin
        if (reset && wr_fire_s && !is_tohost_s && !is_oob_s) begin
            mem_r[idx_s] <= merge_lanes(mem_r[idx_s], mem_wdata, mem_wmask);
        end
    end

    // Control state, read data delivery, tohost capture and sticky error flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_cnt_r    <= CNT_ZERO;
            wr_cnt_r    <= CNT_ZERO;
            rbusy_r     <= 1'b0;
            wbusy_r     <= 1'b0;
            rd_pend_r   <= 32'h0;
            rdata_r     <= 32'h0;
            sim_done_r  <= 1'b0;
            sim_code_r  <= 32'h0;
            oob_err_r   <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            rd_cnt_r <= rd_cnt_s;
            wr_cnt_r <= wr_cnt_s;
            rbusy_r  <= (rd_cnt_s != CNT_ZERO);
            wbusy_r  <= (wr_cnt_s != CNT_ZERO);
            if (proto_s) begin
                proto_err_r <= 1'b1;
            end
            if ((rd_fire_s || wr_fire_s) && is_oob_s) begin
                oob_err_r <= 1'b1;
            end
            if (wr_fire_s && is_tohost_s) begin
                sim_done_r <= 1'b1;
                sim_code_r <= code_merged_s;
            end
            // data is sampled at the request edge and released when the counter expires
            if (rd_fire_s) begin
                if (READ_LAT == 1) begin
                    rdata_r <= rd_val_s;
                end else begin
                    rd_pend_r <= rd_val_s;
                end
            end else if (rd_cnt_r == CNT_ONE) begin
                rdata_r <= rd_pend_r;
            end
        end
    end

    assign mem_rdata = rdata_r;
    assign mem_rbusy = rbusy_r;
    assign mem_wbusy = wbusy_r;
    assign sim_done  = sim_done_r;
    assign sim_code  = sim_code_r;
    assign oob_err   = oob_err_r;
    assign proto_err = proto_err_r;
endmodule

// File: tb/tb_sim_mem_wait.sv
// Self-checking bench for sim_mem_wait: directed vector table, randomized transactions
// against a transaction-level memory model, and protocol/reset corner sequences.
module tb_sim_mem_wait;
    localparam int          DEPTH  = 1024;
    localparam int          RL     = 3;
    localparam int          WL     = 2;
    localparam logic [31:0] TOHOST = 32'h0000_FFF0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, sim_code;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb, mem_rbusy, mem_wbusy, sim_done, oob_err, proto_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] code_m;
    logic        done_m, oob_m, proto_m;

    sim_mem_wait #(
        .INIT_FILE(""), .DEPTH_WORDS(DEPTH), .READ_LAT(RL), .WRITE_LAT(WL), .TOHOST_ADDR(TOHOST)
    ) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
        .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .sim_done(sim_done),
        .sim_code(sim_code), .oob_err(oob_err), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic bit m_is_tohost(input logic [31:0] a);
        return (a & 32'hFFFF_FFFC) == TOHOST;
    endfunction

    // a 1024-word array decodes byte address bits [11:2]; anything above is out of range
    function automatic bit m_is_oob(input logic [31:0] a);
        return !m_is_tohost(a) && (a / 32'd4096 != 32'd0);
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] d,
                                            input logic [3:0] m);
        logic [31:0] em;
        em = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (o & ~em) | (d & em);
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        if (m_is_tohost(a)) begin
            code_m = m_merge(code_m, d, m);
            done_m = 1'b1;
        end else if (m_is_oob(a)) begin
            oob_m = 1'b1;
        end else begin
            mem_m[(a % 32'd4096) / 32'd4] = m_merge(mem_m[(a % 32'd4096) / 32'd4], d, m);
        end
    endtask

    task automatic m_read(input logic [31:0] a, output logic [31:0] v);
        if (m_is_tohost(a)) begin
            v = code_m;
        end else if (m_is_oob(a)) begin
            v = 32'h0;
            oob_m = 1'b1;
        end else begin
            v = mem_m[(a % 32'd4096) / 32'd4];
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_sim_done"},  {31'h0, sim_done},  {31'h0, done_m});
        check({tag, "_sim_code"},  sim_code,           code_m);
        check({tag, "_oob_err"},   {31'h0, oob_err},   {31'h0, oob_m});
        check({tag, "_proto_err"}, {31'h0, proto_err}, {31'h0, proto_m});
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int n;
        @(negedge clk);
        mem_addr = a; mem_wdata = d; mem_wmask = m;
        @(posedge clk); #1;
        mem_wmask = 4'h0; mem_addr = $urandom; mem_wdata = $urandom;
        m_write(a, d, m);
        check_flags("wr");
        n = 0;
        while (mem_wbusy && n < 64) begin
            n++;
            @(posedge clk); #1;
        end
        check("wr_busy_cycles", n, WL - 1);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] got);
        int n;
        logic [31:0] exp;
        @(negedge clk);
        mem_addr = a; mem_rstrb = 1'b1;
        @(posedge clk); #1;
        mem_rstrb = 1'b0; mem_addr = $urandom;
        m_read(a, exp);
        check_flags("rd");
        n = 0;
        while (mem_rbusy && n < 64) begin
            n++;
            @(posedge clk); #1;
        end
        check("rd_busy_cycles", n, RL - 1);
        check("rd_data_model", mem_rdata, exp);
        got = mem_rdata;
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        logic [31:0] got, exp_a, a;
        int          low;

        begin : watchdog_guard
        end
        vecs.push_back('{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 32'h0000_0FF0, 32'hCAFE_F00D, 4'hF, 32'h0});
        vecs.push_back('{1'b1, TOHOST,        32'h0000_0001, 4'hF, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0FF0, 32'h0,         4'h0, 32'hCAFE_F00D});
        vecs.push_back('{1'b0, TOHOST,        32'h0,         4'h0, 32'h0000_0001});
        vecs.push_back('{1'b1, 32'h0000_FFF2, 32'hAB00_0000, 4'h8, 32'h0});
        vecs.push_back('{1'b0, TOHOST,        32'h0,         4'h0, 32'hAB00_0001});
        vecs.push_back('{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_1000, 32'h5555_5555, 4'hF, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'hDEAD_BEEF});

        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        code_m = 32'h0; done_m = 1'b0; oob_m = 1'b0; proto_m = 1'b0;

        reset = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wmask = 4'h0; mem_rstrb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rbusy", {31'h0, mem_rbusy}, 32'h0);
        check("reset_wbusy", {31'h0, mem_wbusy}, 32'h0);
        check("reset_rdata", mem_rdata, 32'h0);
        check_flags("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].mask);
            end else begin
                do_read(vecs[i].addr, got);
                check($sformatf("vec%0d_rdata", i), got, vecs[i].exp);
            end
        end

        low = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (!sim_done) low++;
        end
        check("sim_done_hold", low, 0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 15))
                0:       a = TOHOST | $urandom_range(0, 3);
                1:       a = $urandom | 32'h0000_1000;
                default: a = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
            endcase
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, $urandom, 4'($urandom_range(1, 15)));
            end else begin
                do_read(a, got);
            end
        end

        // second read strobe while the first is still in flight
        m_read(32'h10, exp_a);
        @(negedge clk);
        mem_addr = 32'h10; mem_rstrb = 1'b1;
        @(posedge clk); #1;
        mem_addr = 32'h20;
        @(posedge clk); #1;
        mem_rstrb = 1'b0;
        proto_m = 1'b1;
        check("proto_busy_flag", {31'h0, proto_err}, 32'h1);
        check("proto_busy_rbusy", {31'h0, mem_rbusy}, 32'h1);
        @(posedge clk); #1;
        check("proto_first_rbusy_fall", {31'h0, mem_rbusy}, 32'h0);
        check("proto_first_rdata", mem_rdata, exp_a);

        // read and write at the same edge: only the write happens
        @(negedge clk);
        mem_addr = 32'h40; mem_wdata = 32'h0BAD_CAFE; mem_wmask = 4'hF; mem_rstrb = 1'b1;
        @(posedge clk); #1;
        mem_rstrb = 1'b0; mem_wmask = 4'h0;
        m_write(32'h40, 32'h0BAD_CAFE, 4'hF);
        check("simul_rbusy", {31'h0, mem_rbusy}, 32'h0);
        check("simul_wbusy", {31'h0, mem_wbusy}, 32'h1);
        check("simul_rdata_kept", mem_rdata, exp_a);
        check_flags("simul");
        @(posedge clk); #1;
        do_read(32'h40, got);
        check("simul_write_landed", got, 32'h0BAD_CAFE);

        // reset one cycle into a pending read
        @(negedge clk);
        mem_addr = 32'h40; mem_rstrb = 1'b1;
        @(posedge clk); #1;
        mem_rstrb = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        code_m = 32'h0; done_m = 1'b0; oob_m = 1'b0; proto_m = 1'b0;
        check("midrst_rbusy", {31'h0, mem_rbusy}, 32'h0);
        check("midrst_rdata", mem_rdata, 32'h0);
        check_flags("midrst");
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_late_data", mem_rdata, 32'h0);
        check("midrst_no_late_busy", {31'h0, mem_rbusy}, 32'h0);
        do_read(32'h40, got);
        check("midrst_array_intact", got, 32'h0BAD_CAFE);
        do_read(32'h20, got);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
